// File: rtl/mem_access_pkg.sv
// Shared MIPS decode constants and MEM-stage FSM encoding for mem_access.
package mem_access_pkg;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU) || is_store(op);
  endfunction

  // Halfword on an odd address, or word on a non-multiple of four.
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'd0;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_lane.sv
// Byte-lane steering: byte enables, store replication, load extract/extend.
// Purely combinational; BIG_ENDIAN selects which lane holds byte offset 0.
module mem_lane
  import mem_access_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [1:0]  w_lane;
  logic        w_hi;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection; halfwords only look at Addr[1], words ignore the offset.
  always_comb begin
    w_lane = BIG_ENDIAN ? (2'd3 - i_off) : i_off;
    w_hi   = BIG_ENDIAN ? ~i_off[1] : i_off[1];
    w_byte = i_rdata[8*w_lane +: 8];
    w_half = w_hi ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Per-size enables, replicated store data and extended load data.
  always_comb begin
    o_be    = 4'hF;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_op)
      OP_LB, OP_LBU, OP_SB: begin
        o_be    = 4'b0001 << w_lane;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = (i_op == OP_LB) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      end
      OP_LH, OP_LHU, OP_SH: begin
        o_be    = w_hi ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = (i_op == OP_LH) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MIPS MEM stage: req/ack data-bus loads/stores with wait states, passthrough
// for non-memory ops. Optional misaligned-access trap: MEM_MISALIGN_TRAP_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [31:0] Ins,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  output logic [31:0] Result,
  output logic        Done,
  output logic        Stall,
  output logic        AddrErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  mem_state_e  r_state, w_next;
  logic [5:0]  r_op;
  logic [1:0]  r_off;
  logic [31:0] r_result, r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_we;

  logic [5:0]  w_in_op, w_op;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_rdata;
  logic        w_trap;
  logic        w_unused_ins;

  assign w_in_op      = Ins[31:26];
  assign w_unused_ins = ^Ins[25:0];

  // Lane logic sees the incoming instruction while idle, the latched one after.
  assign w_op  = (r_state == MEM_IDLE) ? w_in_op : r_op;
  assign w_off = (r_state == MEM_IDLE) ? Addr[1:0] : r_off;

  mem_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .i_op    (w_op),
    .i_off   (w_off),
    .i_wdata (Wdata),
    .i_rdata (mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_err;
  assign w_trap = misaligned(w_in_op, Addr[1:0]);

  // Error flag is raised only for the RESP cycle of a trapped access.
  always_ff @(posedge CLK) begin
    if (RST)                                r_err <= 1'b0;
    else if (r_state == MEM_IDLE && Start)  r_err <= w_trap;
    else if (r_state == MEM_RESP)           r_err <= 1'b0;
  end
  assign AddrErr = r_err;
`else
  assign w_trap  = 1'b0;
  assign AddrErr = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= MEM_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: memory ops go through REQ, everything else straight to RESP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      MEM_IDLE: if (Start) w_next = (is_mem(w_in_op) && !w_trap) ? MEM_REQ : MEM_RESP;
      MEM_REQ:  if (mem_ack) w_next = MEM_RESP;
      MEM_RESP: w_next = MEM_IDLE;
      default:  w_next = MEM_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    Done    = (r_state == MEM_RESP);
    Stall   = (r_state == MEM_REQ);
    mem_req = (r_state == MEM_REQ);
  end

  // Datapath: latch bus fields at Start, capture load data on ack.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op     <= '0;
      r_off    <= '0;
      r_result <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_we     <= 1'b0;
    end else begin
      case (r_state)
        MEM_IDLE: if (Start) begin
          r_op  <= w_in_op;
          r_off <= Addr[1:0];
          if (is_mem(w_in_op) && !w_trap) begin
            r_addr  <= {Addr[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_we    <= is_store(w_in_op);
          end else begin
            r_result <= Addr;
          end
        end
        MEM_REQ: if (mem_ack) begin
          r_result <= r_we ? 32'd0 : w_rdata;
          r_addr   <= '0;
          r_be     <= '0;
          r_wdata  <= '0;
          r_we     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign Result    = r_result;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;

  // Upstream must not present a new Start while an access is in progress.
  a_start_idle: assert property (@(posedge CLK) disable iff (RST)
                                 Start |-> r_state == MEM_IDLE);

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access (BIG_ENDIAN=1); honours MEM_MISALIGN_TRAP_EN if defined.
module tb_mem_access;

  localparam bit BE = 1'b1;

  logic        CLK = 1'b0, RST = 1'b1, Start = 1'b0;
  logic [31:0] Ins = '0, Addr = '0, Wdata = '0;
  logic [31:0] Result, mem_addr, mem_wdata;
  logic        Done, Stall, AddrErr, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  mem_access #(.BIG_ENDIAN(BE)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Ins(Ins), .Addr(Addr), .Wdata(Wdata),
    .Result(Result), .Done(Done), .Stall(Stall), .AddrErr(AddrErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          mem;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wrep;
    logic [31:0] res;
    bit          err;
  } exp_t;

  int   checks = 0, errors = 0;
  exp_t exp_q[$];
  int   cur_wait = 1;
  logic [31:0] cur_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, ex);
    end
  endtask

  // Model: memory viewed as 4 addressable bytes mapped to lanes by endianness;
  // a load assembles n bytes starting at the (possibly forced) byte offset.
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    int n, off, lane;
    bit sgn, st;
    logic [31:0] v;
    e.mem = 0; e.we = 0; e.be = '0; e.addr = '0; e.wrep = '0; e.res = a; e.err = 0;
    sgn = 0; st = 0;
    case (op)
      6'h20: begin n = 1; sgn = 1; end
      6'h24: n = 1;
      6'h28: begin n = 1; st = 1; end
      6'h21: begin n = 2; sgn = 1; end
      6'h25: n = 2;
      6'h29: begin n = 2; st = 1; end
      6'h23: n = 4;
      6'h2B: begin n = 4; st = 1; end
      default: return e;
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0)) begin
      e.err = 1;
      return e;
    end
`endif
    off = (n == 1) ? int'(a[1:0]) : (n == 2) ? 2 * int'(a[1]) : 0;
    e.mem = 1; e.we = st; e.addr = {a[31:2], 2'b00};
    v = '0;
    for (int k = 0; k < n; k++) begin
      lane = BE ? 3 - (off + k) : off + k;
      e.be[lane] = 1'b1;
      if (BE) v = (v << 8) | {24'd0, rd[8*lane +: 8]};
      else    v = v | ({24'd0, rd[8*lane +: 8]} << (8*k));
    end
    if (sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    e.res  = st ? 32'd0 : v;
    e.wrep = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
    return e;
  endfunction

  // Bus slave: acks on the cur_wait-th cycle of a request.
  int req_n = 0;
  always @(posedge CLK) begin
    #1;
    if (mem_req) begin
      req_n++;
      mem_ack   = (req_n == cur_wait);
      mem_rdata = mem_ack ? cur_rdata : 32'h0BAD_0BAD;
    end else begin
      req_n   = 0;
      mem_ack = 1'b0;
    end
  end

  // Single compare process, sampled mid-cycle.
  bit   busy = 0, acked = 0, rst_prev = 0;
  int   cnt = 0;
  exp_t cur;
  always @(negedge CLK) begin
    if (RST) begin
      if (rst_prev) begin
        chk("rst_result", Result, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_adderr", {31'd0, AddrErr}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
      end
      busy = 0; acked = 0;
    end else if (!busy) begin
      chk("idle_done", {31'd0, Done}, 32'd0);
      chk("idle_stall", {31'd0, Stall}, 32'd0);
      chk("idle_req", {31'd0, mem_req}, 32'd0);
      chk("idle_adderr", {31'd0, AddrErr}, 32'd0);
      if (Start) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL start_without_model_entry");
        end else begin
          cur = exp_q.pop_front();
          busy = 1; cnt = 0; acked = 0;
        end
      end
    end else begin
      cnt++;
      if (!cur.mem || acked) begin
        chk("done", {31'd0, Done}, 32'd1);
        chk("result", Result, cur.res);
        chk("resp_stall", {31'd0, Stall}, 32'd0);
        chk("resp_req", {31'd0, mem_req}, 32'd0);
        chk("adderr", {31'd0, AddrErr}, {31'd0, cur.err});
        busy = 0;
      end else begin
        chk("req", {31'd0, mem_req}, 32'd1);
        chk("stall", {31'd0, Stall}, 32'd1);
        chk("req_done", {31'd0, Done}, 32'd0);
        chk("req_adderr", {31'd0, AddrErr}, 32'd0);
        chk("we", {31'd0, mem_we}, {31'd0, cur.we});
        chk("be", {28'd0, mem_be}, {28'd0, cur.be});
        chk("addr", mem_addr, cur.addr);
        if (cur.we) chk("wdata", mem_wdata, cur.wrep);
        if (mem_ack) acked = 1;
        if (cnt > 40) begin
          errors++;
          $display("FAIL req_timeout cycles=%0d", cnt);
          busy = 0;
        end
      end
    end
    rst_prev = RST;
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int wt);
    cur_wait = wt; cur_rdata = rd;
    @(posedge CLK); #2;
    Ins = {op, 26'h2AA_AAAA}; Addr = a; Wdata = wd; Start = 1'b1;
    exp_q.push_back(model(op, a, wd, rd));
    @(posedge CLK); #2;
    Start = 1'b0; Ins = '0; Addr = $urandom; Wdata = $urandom;
  endtask

  task automatic run(input logic [5:0] op, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int wt);
    bit seen;
    issue(op, a, wd, rd, wt);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (Done) seen = 1;
      else begin @(posedge CLK); #2; end
    end
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout op=%h addr=%h", op, a);
    end
    @(posedge CLK); #2;
  endtask

  exp_t p;
  initial begin
    // Hand-computed pins on the model itself.
    p = model(6'h20, 32'h203, 32'h0, 32'h1122_3380);
    chk("pin_lb_res", p.res, 32'hFFFF_FF80);
    chk("pin_lb_be", {28'd0, p.be}, 32'h1);
    p = model(6'h24, 32'h203, 32'h0, 32'h1122_3380);
    chk("pin_lbu_res", p.res, 32'h0000_0080);
    p = model(6'h29, 32'h302, 32'h0000_ABCD, 32'h0);
    chk("pin_sh_be", {28'd0, p.be}, 32'h3);
    chk("pin_sh_wdata", p.wrep, 32'hABCD_ABCD);
    p = model(6'h2B, 32'h100, 32'hDEAD_BEEF, 32'h0);
    chk("pin_sw_be", {28'd0, p.be}, 32'hF);

    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;

    run(6'h00, 32'h0000_1234, 32'h0, 32'h0, 1);          // ADDU passthrough
    run(6'h2B, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 3);  // SW, 3 wait cycles
    run(6'h20, 32'h0000_0203, 32'h0, 32'h1122_3380, 1);  // LB
    run(6'h24, 32'h0000_0203, 32'h0, 32'h1122_3380, 1);  // LBU
    run(6'h29, 32'h0000_0302, 32'h0000_ABCD, 32'h0, 2);  // SH
    run(6'h21, 32'h0000_0200, 32'h0, 32'h8001_1234, 1);  // LH upper half
    run(6'h25, 32'h0000_0202, 32'h0, 32'h8001_F234, 2);  // LHU lower half
    run(6'h23, 32'h0000_0404, 32'h0, 32'hCAFE_F00D, 4);  // LW
    run(6'h20, 32'h0000_0200, 32'h0, 32'h7F00_0000, 1);  // LB positive
    run(6'h28, 32'h0000_0201, 32'h0000_00A5, 32'h0, 1);  // SB

    // Reset in the middle of an outstanding LW: abandoned, no Done.
    issue(6'h23, 32'h0000_0500, 32'h0, 32'h5555_5555, 6);
    @(posedge CLK); #2;
    RST = 1'b1;
    @(posedge CLK); #2;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    run(6'h23, 32'h0000_0508, 32'h0, 32'h1234_5678, 1);  // normal LW after reset

    run(6'h23, 32'h0000_0401, 32'h0, 32'hA1B2_C3D4, 2);  // misaligned LW
    run(6'h21, 32'h0000_0203, 32'h0, 32'h1357_9BDF, 1);  // misaligned LH
    run(6'h08, 32'hFFFF_FFFC, 32'h0, 32'h0, 1);          // ADDI passthrough

    repeat (3) @(posedge CLK);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL model_queue_leftover n=%0d", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the MIPS datapath, directly downstream of the execute stage.
- Consumes the ALU result (effective address or arithmetic result), store data (rt value) and the instruction word.
- Performs byte/halfword/word loads and stores over a req/ack data-memory bus with wait states; extends load data; raises stall while a bus access is outstanding.
- Non-memory instructions pass the ALU result through unchanged.

Parameters:
- BIG_ENDIAN, 1, byte-lane order: 1 = MIPS big-endian (byte offset 0 on bits 31:24); 0 = little-endian (byte offset 0 on bits 7:0).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous reset, active-high
- Start  in  1  one-cycle pulse: execute-stage outputs valid this cycle
- Ins  in  32  instruction word; op = Ins[31:26]
- Addr  in  32  ALU result (effective address or passthrough value)
- Wdata  in  32  store data (rt)
- Result  out  32  load data (extended) or passthrough value
- Done  out  1  one-cycle pulse: Result valid
- Stall  out  1  high while an access is in flight; upstream holds
- AddrErr  out  1  misaligned-access flag (only with optional feature)
- mem_req  out  1  bus request
- mem_we  out  1  1 = store
- mem_addr  out  32  word address, {Addr[31:2],2'b00}
- mem_be  out  4  byte enables, bit i = data[8i+7:8i]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. Any other op is passthrough.
- Reset values: Result = 0, Done = 0, Stall = 0, AddrErr = 0, mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0. FSM goes to IDLE.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Start with passthrough op: latch Addr into Result, go to RESP.
  - Start with load/store op: latch op, offset Addr[1:0] and bus fields; assert mem_req next cycle; go to REQ.
  - Stall = 1 from the cycle after Start until Done.
- REQ:
  - mem_req and all bus outputs are held stable until mem_ack.
  - On mem_ack: drop mem_req the next cycle, capture the extended load data (stores: Result = 0), go to RESP.
- RESP: Done = 1 for exactly one cycle, Stall = 0, return to IDLE.
- Latency:
  - Passthrough: Done 1 cycle after Start.
  - Memory access: Done = 1 cycle after the mem_ack cycle. Minimum total latency is 3 cycles (ack in the first REQ cycle).
- Start outside IDLE is ignored; it is a protocol error and the assertion fires. mem_ack outside REQ is ignored.
- Byte lanes, offset o = Addr[1:0]:
  - Byte: lane = BIG_ENDIAN ? 3-o : o.
  - Half: lanes {3,2} when Addr[1]=0 and BIG_ENDIAN=1, otherwise mirrored; Addr[0] ignored.
  - Store data is replicated: SB {4{Wdata[7:0]}}, SH {2{Wdata[15:0]}}, SW Wdata. mem_be selects the lanes.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW raw word.
- RST asserted mid-access: the FSM returns to IDLE and mem_req drops on the next edge. The outstanding bus transaction is abandoned and Done is not issued.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with Addr[0] = 1, or LW/SW with Addr[1:0] != 0, issues no bus request.
  - Go directly to RESP: Done pulses with AddrErr = 1 for that cycle; Result = Addr (bad virtual address).
- Undefined:
  - The offending low bits are ignored: halfword forced to Addr[1], word forced aligned.
  - AddrErr is tied 0.

Decomposition:
- Shared package (common_param.vh):
  - The load/store opcode constants above, alongside the existing R_FORM/ADDI constants.
  - FSM state encodings MEM_IDLE = 2'd0, MEM_REQ = 2'd1, MEM_RESP = 2'd2.
- One sub-module, mem_lane: combinational byte-enable generation, store replication and load extraction/extension, parameterised by BIG_ENDIAN. It is instantiated once in the FSM module.

Test Plan:
- Passthrough: Ins op 0x00 (ADDU), Addr = 0x0000_1234, Start -> Done 1 cycle later, Result = 0x0000_1234, mem_req never asserted.
- SW with wait states:
  - Stimulus: Addr = 0x100, Wdata = 0xDEADBEEF, mem_ack after 3 REQ cycles.
  - Response: mem_we = 1, mem_be = 4'hF, mem_addr = 0x100, bus held stable 3 cycles, Stall high throughout, Done 1 cycle after ack.
- LB sign/zero, BIG_ENDIAN = 1: Addr = 0x203, mem_rdata = 0x1122_3380 ->
  - LB: mem_be = 4'b0001, Result = 0xFFFF_FF80.
  - LBU: Result = 0x0000_0080.
- SH at Addr = 0x302, Wdata = 0x0000_ABCD -> mem_be = 4'b0011 (BE) / 4'b1100 (LE), mem_wdata = 0xABCD_ABCD.
- Reset mid-access: assert RST during REQ -> next edge mem_req = 0, Stall = 0, no Done. A following LW completes normally.
- With MEM_MISALIGN_TRAP_EN: LW at Addr = 0x401 -> no mem_req, Done and AddrErr pulse together 1 cycle after Start, Result = 0x401.
